tap_slave: RTL
==============

TAP_SLAVE -- requirements
Module: tap_slave

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0001, the 32-bit device identification value.
REQ-002 SHALL have parameter ADDR_W, default 8, the register-bus address width.
REQ-003 SHALL have parameter DATA_W, default 16, the register-bus data width.
REQ-004 SHALL have port clk, input, 1, the test clock (TCK): one clock; sampling on rising edge, TDO launch on falling edge.
REQ-005 SHALL have port rstb, input, 1: reset is asynchronous and active-low.
REQ-006 SHALL have port tms, input, 1, test mode select, sampled on rising clk.
REQ-007 SHALL have port tdi, input, 1, serial data in, sampled on rising clk.
REQ-008 SHALL have port tdo, output, 1, serial data out, updated on falling clk.
REQ-009 SHALL have port tdo_en, output, 1, high only while in Shift-IR or Shift-DR, updated on falling clk.
REQ-010 SHALL have port reg_addr, output, ADDR_W, register-bus address.
REQ-011 SHALL have port reg_wdata, output, DATA_W, register-bus write data.
REQ-012 SHALL have port reg_wr, output, 1, one-cycle write strobe.
REQ-013 SHALL have port reg_rd, output, 1, one-cycle read strobe.
REQ-014 SHALL have port reg_rdata, input, DATA_W, read data for the current reg_addr, valid one cycle after reg_rd.

Function
REQ-015 SHALL implement the 16-state IEEE 1149.1 TAP FSM (Test-Logic-Reset, Run-Test/Idle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR), transitions on rising clk per tms.
REQ-016 SHALL reach Test-Logic-Reset from any state after at most five consecutive rising edges with tms=1.
REQ-017 SHALL use a 4-bit IR: 4'b0001 IDCODE, 4'b0010 REG_ACCESS, 4'b1111 BYPASS; any other code selects BYPASS.
REQ-018 SHALL load 4'b0101 into the IR shift register in Capture-IR and transfer it to the IR in Update-IR.
REQ-019 SHALL force the IR to IDCODE whenever the FSM is in Test-Logic-Reset.
REQ-020 SHALL shift all registers LSB first: tdi enters the MSB, the LSB drives tdo, one bit per rising clk in Shift state.
REQ-021 SHALL give BYPASS a 1-bit DR that captures 0, so tdo equals tdi delayed by one clk.
REQ-022 SHALL give IDCODE a 32-bit DR that captures IDCODE in Capture-DR; Update-DR has no effect.
REQ-023 SHALL give REG_ACCESS a DR of 1+ADDR_W+DATA_W bits (25 by default): bit0 rw (1=write), bits[ADDR_W:1] addr, upper DATA_W bits data.
REQ-024 SHALL capture {reg_rdata, reg_addr, 1'b0} into the REG_ACCESS DR in Capture-DR.
REQ-025 SHALL, on the rising edge leaving Update-DR under REG_ACCESS, load reg_addr from the addr field; with rw=1 also load reg_wdata and assert reg_wr for exactly one cycle, with rw=0 assert reg_rd for exactly one cycle.
REQ-026 SHALL keep reg_wr and reg_rd mutually exclusive and never asserted outside the REQ-025 case.
REQ-027 SHALL keep DR and IR contents unchanged in Pause-DR, Pause-IR, Exit1 and Exit2, so shifting resumes without loss.
REQ-028 SHALL drive tdo=0 whenever tdo_en=0.
REQ-029 SHALL, on an Update-DR under REG_ACCESS with an incomplete shift (fewer than 25 bits), still act on the shift-register contents as they stand, without a length check.

Reset
REQ-030 SHALL, while rstb=0, force state to Test-Logic-Reset, IR to IDCODE, all shift registers to 0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, tdo=0, tdo_en=0.
REQ-031 SHALL abort any shift or pending strobe when rstb is asserted mid-operation; no reg_wr is issued for an aborted access.
REQ-032 SHALL leave reset on the first rising clk after rstb deasserts, from Test-Logic-Reset.

Verification
REQ-033 Reset then scan 32 DR bits with no IR load -> tdo reads 32'h1000_0001 LSB first.
REQ-034 IR load 4'b1111, shift tdi pattern 1,0,1,1 -> tdo gives 0,1,0,1 (one-bit delay).
REQ-035 IR load 4'b0010, shift {16'hA5C3, 8'h3C, 1'b1} -> after Update-DR, reg_addr=8'h3C, reg_wdata=16'hA5C3, reg_wr high one cycle, reg_rd stays 0.
REQ-036 REG_ACCESS read: shift addr 8'h3C with rw=0 (reg_rd pulses), model returns 16'h1234, next DR scan -> tdo bits 24:9 read 16'h1234, bits 8:1 read 8'h3C.
REQ-037 Mid-shift Pause-DR for 10 clocks, then resume -> same result as REQ-035; five tms=1 from Shift-DR -> Test-Logic-Reset, IR=IDCODE, no reg_wr.
REQ-038 rstb pulsed low during REG_ACCESS Shift-DR -> all outputs at REQ-030 values, no strobe, next DR scan returns IDCODE.

Source files
------------

// File: rtl/tap_slave.sv
// IEEE 1149.1 TAP slave with IDCODE, BYPASS and a REG_ACCESS data register.
// A REG_ACCESS scan becomes one read or write on a simple register bus.
module tap_slave #(
  parameter logic [31:0] IDCODE = 32'h1000_0001,
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam int         RA_W       = 1 + ADDR_W + DATA_W;
  localparam logic [3:0] IR_IDCODE  = 4'b0001;
  localparam logic [3:0] IR_REG     = 4'b0010;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        ir_q, ir_d;
  logic [3:0]        ir_sr_q, ir_sr_d;
  logic              byp_q, byp_d;
  logic [31:0]       idc_sr_q, idc_sr_d;
  logic [RA_W-1:0]   ra_sr_q, ra_sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              tdo_q, tdo_d;
  logic              tdo_en_q, tdo_en_d;
  logic              sel_idc, sel_reg;

  // Unknown instruction codes fall through to BYPASS.
  assign sel_idc = (ir_q == IR_IDCODE);
  assign sel_reg = (ir_q == IR_REG);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PA_DR;
      PA_DR:  state_d = tms ? EX2_DR : PA_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PA_IR;
      PA_IR:  state_d = tms ? EX2_IR : PA_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Register actions happen on the edge leaving the named state; the
  // Pause/Exit states simply hold every register.
  always_comb begin
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    byp_d    = byp_q;
    idc_sr_d = idc_sr_q;
    ra_sr_d  = ra_sr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    case (state_q)
      TLR:    ir_d    = IR_IDCODE;
      CAP_IR: ir_sr_d = IR_CAPTURE;
      SH_IR:  ir_sr_d = {tdi, ir_sr_q[3:1]};
      UPD_IR: ir_d    = ir_sr_q;
      CAP_DR: begin
        if (sel_idc)      idc_sr_d = IDCODE;
        else if (sel_reg) ra_sr_d  = {reg_rdata, addr_q, 1'b0};
        else              byp_d    = 1'b0;
      end
      SH_DR: begin
        if (sel_idc)      idc_sr_d = {tdi, idc_sr_q[31:1]};
        else if (sel_reg) ra_sr_d  = {tdi, ra_sr_q[RA_W-1:1]};
        else              byp_d    = tdi;
      end
      UPD_DR: begin
        // No length check: a short scan acts on whatever the register holds.
        if (sel_reg) begin
          addr_d = ra_sr_q[ADDR_W:1];
          if (ra_sr_q[0]) begin
            wdata_d = ra_sr_q[RA_W-1:ADDR_W+1];
            wr_d    = 1'b1;
          end else begin
            rd_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= TLR;
      ir_q     <= IR_IDCODE;
      ir_sr_q  <= '0;
      byp_q    <= 1'b0;
      idc_sr_q <= '0;
      ra_sr_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      byp_q    <= byp_d;
      idc_sr_q <= idc_sr_d;
      ra_sr_q  <= ra_sr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // TDO is launched on the falling edge so the host can sample on the rising one.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_en_d = 1'b1;
      tdo_d    = ir_sr_q[0];
    end else if (state_q == SH_DR) begin
      tdo_en_d = 1'b1;
      if (sel_idc)      tdo_d = idc_sr_q[0];
      else if (sel_reg) tdo_d = ra_sr_q[0];
      else              tdo_d = byp_q;
    end
  end

  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo       = tdo_q;
  assign tdo_en    = tdo_en_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;

endmodule
